// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-decode stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package imm_pkg;

  // Immediate format tag. NONE must stay at encoding 0: the stage resets its
  // payload registers to all-zeros and relies on that reading back as NONE.
  typedef enum logic [3:0] {
    NONE    = 4'd0,
    R       = 4'd1,
    I       = 4'd2,
    I_SHAMT = 4'd3,
    S       = 4'd4,
    B       = 4'd5,
    U       = 4'd6,
    J       = 4'd7,
    CSR_Z   = 4'd8
  } imm_fmt_e;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_I_TYPE   = 7'b0010011;  // OP-IMM
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_I_W_TYPE = 7'b0011011;  // OP-IMM-32 (RV64 only)
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_AMO      = 7'b0101111;
  localparam logic [6:0] OPCODE_R_TYPE   = 7'b0110011;  // OP
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_R_W_TYPE = 7'b0111011;  // OP-32
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instruction word -> XLEN immediate, format tag, illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports: instr_i in, imm_o / fmt_o / illegal_o out.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_csr, imm_shamt, imm_shamt_w;

  assign funct3   = instr_i[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i   = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s   = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b   = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j   = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_u   = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
  assign imm_csr = {{(XLEN-5){1'b0}}, instr_i[19:15]};
  // RV64 shifts carry a 6-bit shamt; on RV32 bit 25 belongs to funct7 and is ignored.
  assign imm_shamt   = (XLEN == 64) ? {{(XLEN-6){1'b0}}, instr_i[25:20]}
                                    : {{(XLEN-5){1'b0}}, instr_i[24:20]};
  // Word-op shifts always have a 5-bit shamt.
  assign imm_shamt_w = {{(XLEN-5){1'b0}}, instr_i[24:20]};

  always_comb begin
    imm_o     = '0;
    fmt_o     = NONE;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OPCODE_I_TYPE: begin
        if (is_shift) begin
          imm_o = imm_shamt;
          fmt_o = I_SHAMT;
        end else begin
          imm_o = imm_i;
          fmt_o = I;
        end
      end
      OPCODE_LOAD, OPCODE_JALR: begin
        imm_o = imm_i;
        fmt_o = I;
      end
      OPCODE_STORE: begin
        imm_o = imm_s;
        fmt_o = S;
      end
      OPCODE_BRANCH: begin
        imm_o = imm_b;
        fmt_o = B;
      end
      OPCODE_JAL: begin
        imm_o = imm_j;
        fmt_o = J;
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        imm_o = imm_u;
        fmt_o = U;
      end
      OPCODE_SYSTEM: begin
        if (funct3[2]) begin
          imm_o = imm_csr;
          fmt_o = CSR_Z;
        end else begin
          imm_o = imm_i;
          fmt_o = I;
        end
      end
      OPCODE_I_W_TYPE: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            imm_o = imm_shamt_w;
            fmt_o = I_SHAMT;
          end else begin
            imm_o = imm_i;
            fmt_o = I;
          end
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPCODE_R_TYPE, OPCODE_R_W_TYPE, OPCODE_AMO: begin
        fmt_o = R;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer (main M + skid S), FIFO order.
// Latency: 1 cycle; full throughput with registered in_ready_o; flush_i drops both entries.
// Backpressure: out_ready_i low holds M, next word lands in S, in_ready_o drops until S drains.
// Ports: clk_i, rst_i (async, active-high), flush_i, in_valid_i/in_ready_o/instr_i/pc_i,
//        out_valid_o/out_ready_i/imm_o/fmt_o/illegal_o/instr_o/pc_o.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  entry_t          in_ent;

  entry_t m_q, m_d, s_q, s_d;
  logic   m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic   rdy_q;
  logic   accept, fire;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr_i  (instr_i),
    .imm_o    (dec_imm),
    .fmt_o    (dec_fmt),
    .illegal_o(dec_illegal)
  );

  always_comb begin
    in_ent         = '0;
    in_ent.instr   = instr_i;
    in_ent.pc      = pc_i;
    in_ent.imm     = dec_imm;
    in_ent.fmt     = dec_fmt;
    in_ent.illegal = dec_illegal;
  end

  assign accept = in_valid_i & rdy_q;
  assign fire   = m_vld_q & out_ready_i;

  // rdy_q tracks !s_vld_q, so an accept never coincides with a pending S->M move.
  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush_i) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q || fire) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else begin
        m_vld_d = accept;
        if (accept) m_d = in_ent;
      end
    end else if (accept) begin
      s_d     = in_ent;
      s_vld_d = 1'b1;
    end
  end

  // Payload reset to all-zeros gives imm/instr/pc = 0 and fmt = NONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      rdy_q   <= !s_vld_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = m_vld_q;
  assign imm_o       = m_q.imm;
  assign fmt_o       = m_q.fmt;
  assign illegal_o   = m_q.illegal;
  assign instr_o     = m_q.instr;
  assign pc_o        = m_q.pc;

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-generation stage between fetch and execute. It accepts one 32-bit instruction per cycle over a valid/ready handshake and produces the XLEN-wide immediate, a format tag and an illegal flag one cycle later. Beyond plain sign-extension, it also decodes:
- shift-amount immediates (I_SHAMT),
- CSR zero-extended immediates (CSR_Z),
- RV64 word-op shifts (opcode 0011011).

A two-entry skid buffer gives full throughput with a registered `in_ready_o`, and `flush_i` kills in-flight entries on redirect.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `flush_i`  in  1  synchronous kill of all buffered entries
- `in_valid_i`  in  1  upstream instruction valid
- `in_ready_o`  out  1  stage can accept; registered
- `instr_i`  in  32  instruction word
- `pc_i`  in  XLEN  instruction address, passed through
- `out_valid_o`  out  1  result valid
- `out_ready_i`  in  1  downstream accepts
- `imm_o`  out  XLEN  decoded immediate
- `fmt_o`  out  `imm_fmt_e`  format tag
- `illegal_o`  out  1  opcode not recognised
- `instr_o`  out  32  instruction, passed through
- `pc_o`  out  XLEN  pc, passed through

## Operation
Immediate extraction. All immediates are sign-extended from instr[31] to XLEN unless stated otherwise.
- OP-IMM (0010011) with funct3 001/101 → I_SHAMT. Zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
- Other OP-IMM, LOAD, JALR → I, instr[31:20].
- STORE → S, {instr[31:25], instr[11:7]}.
- BRANCH → B, {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- JAL → J, {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- LUI, AUIPC → U, {instr[31:12], 12'b0}, sign-extended for XLEN=64.
- SYSTEM with funct3[2]=1 → CSR_Z, zero-extended instr[19:15].
- SYSTEM with funct3[2]=0 → I.
- OP-IMM-32 (0011011):
  - XLEN=64: funct3 001/101 → I_SHAMT (instr[24:20]); otherwise I.
  - XLEN=32: illegal.
- R-type (OP, OP-32, AMO) → R, imm 0.
- Anything else → NONE, imm 0, `illegal_o`=1.

Buffer behaviour:
- Main register M drives the outputs. Skid register S catches the accepted word when M is stalled.
- `in_ready_o` = !S.valid, registered.
- Accept = `in_valid_i` & `in_ready_o`.
- Output fire = `out_valid_o` & `out_ready_i`.
- M empty, or firing, with S empty: accept loads M.
- M held (valid & !out_ready_i) and accept: load S.
- M fires with S valid: S moves to M, S clears, `in_ready_o` rises next cycle.
- Order is strictly FIFO.
- `flush_i` overrides everything: M.valid and S.valid clear next cycle, and any same-cycle accept is discarded.

## Timing
- Latency 1 cycle: instruction accepted at edge n appears on the outputs after edge n, i.e. valid in cycle n+1.
- Throughput 1 per cycle when `out_ready_i` is high.
- Payload is held stable while `out_valid_o` is high and `out_ready_i` is low.
- Reset values:
  - `out_valid_o`=0, `in_ready_o`=1
  - `imm_o`, `instr_o`, `pc_o`=0
  - `fmt_o`=NONE, `illegal_o`=0
- Reset asserted mid-stream drops all entries immediately, asynchronously.
- Flush with both entries full: both drop, and `in_ready_o`=1 the next cycle.
- Payload registers may be left un-reset only if gated by valid; the reset values above are still required.

## Structure
- Package `imm_pkg`:
  - `imm_fmt_e` {NONE, R, I, I_SHAMT, S, B, U, J, CSR_Z}
  - opcode localparams, taken from the existing `OPCODE_*` definitions in definitions.svh
  - `OPCODE_I_W_TYPE` (0011011)
- Sub-module `imm_extract`: combinational, parameter XLEN. Takes instr, produces imm, fmt and illegal.
- Top-level `imm_decode_stage` contains only the skid-buffer control and registers.
- Estimated RTL size: 200–300 lines.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) → next cycle: `imm_o`=0xFFFFFFFF, fmt I. 0xFE000EE3 (beq -4) → 0xFFFFFFFC, fmt B.
- 0x01F09093 (slli 31) → imm 31, I_SHAMT. 0x4030D093 (srai 3) → imm 3, funct7 excluded. 0x3002D073 (csrrwi) → imm 5, CSR_Z. 0x0000007F → imm 0, NONE, illegal=1.
- XLEN=64, 0x800000B7 (lui x1,0x80000) → 0xFFFFFFFF80000000. slli with shamt 63 → imm 63.
- Back-pressure: hold `out_ready_i` low, push A, B, C.
  - A and B are accepted; `in_ready_o` drops after B; C waits.
  - Release `out_ready_i`: outputs appear in order A, B, C with no loss or duplication.
- Flush with M and S full plus a same-cycle accept → `out_valid_o`=0 next cycle, `in_ready_o`=1, and the flushed words never appear.
- Assert `rst_i` asynchronously mid-stream → outputs immediately take their reset values. Random valid/ready stress checks FIFO order against a reference model.
